hwag_cap_filter: RTL

Upstream input stage of the hardware angle generator: conditions the raw crank VR comparator signal before it reaches the tooth-period capture logic.
- Synchronizes and digitally debounces the raw input.
- Selects the active edge.
- Measures edge-to-edge period in clk cycles.
- Rejects edges closer than a programmable minimum and flags loss of signal past a programmable maximum.
- Outputs are a filtered level, a one-cycle capture strobe with period, and error pulses.

---
 rtl/hwag_cap_filter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/hwag_cap_filter.sv
// Crank VR input conditioning: 2-FF sync, debounce, edge select, period measure, min/max checks.
// Optional reject counter is built only when HWAG_CAP_STAT_EN is defined.
module hwag_cap_filter #(
    parameter int FILT_W = 8,
    parameter int PCNT_W = 24
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              en,
    input  logic              cap_in,
    input  logic [FILT_W-1:0] filt_top,
    input  logic              edge_sel,
    input  logic [PCNT_W-1:0] cmin,
    input  logic [PCNT_W-1:0] cmax,
    input  logic              stat_clr,
    output logic              cap_lvl,
    output logic              cap_stb,
    output logic [PCNT_W-1:0] cap_per,
    output logic              cap_first,
    output logic              cap_short,
    output logic              cap_to,
    output logic [15:0]       cap_rej_cnt
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    logic              r_sync1;
    logic              r_sync2;
    logic              r_lvl;
    logic [FILT_W-1:0] r_fcnt;
    logic              r_edge;

    state_t            r_state;
    state_t            w_state_next;
    logic [PCNT_W-1:0] r_pcnt;
    logic [PCNT_W-1:0] w_pcnt_next;
    logic [PCNT_W-1:0] r_per;
    logic [PCNT_W-1:0] w_per_next;
    logic [PCNT_W-1:0] w_pcnt_inc;

    logic              r_stb;
    logic              r_first;
    logic              r_short;
    logic              r_to;
    logic              w_stb;
    logic              w_first;
    logic              w_short;
    logic              w_to;

    logic              w_differ;
    logic              w_toggle;
    logic              w_edge;

    assign w_differ = (r_sync2 != r_lvl);
    assign w_toggle = w_differ && (r_fcnt == filt_top);
    // Level after the toggle is ~r_lvl; match it against the selected edge direction.
    assign w_edge   = w_toggle && ((~r_lvl) == edge_sel);

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_lvl   <= 1'b0;
            r_fcnt  <= '0;
            r_edge  <= 1'b0;
        end else begin
            r_sync1 <= cap_in;
            r_sync2 <= r_sync1;
            r_edge  <= w_edge;
            if (!w_differ) begin
                r_fcnt <= '0;
            end else if (w_toggle) begin
                r_lvl  <= ~r_lvl;
                r_fcnt <= '0;
            end else begin
                r_fcnt <= r_fcnt + FILT_W'(1);
            end
        end
    end

    assign w_pcnt_inc = (&r_pcnt) ? r_pcnt : (r_pcnt + PCNT_W'(1));

    always_comb begin
        w_state_next = r_state;
        w_pcnt_next  = r_pcnt;
        w_per_next   = r_per;
        w_stb        = 1'b0;
        w_first      = 1'b0;
        w_short      = 1'b0;
        w_to         = 1'b0;
        if (!en) begin
            w_state_next = ST_IDLE;
            w_pcnt_next  = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_pcnt_next = '0;
                    if (r_edge) begin
                        w_first      = 1'b1;
                        w_pcnt_next  = PCNT_W'(1);
                        w_state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    // An edge always wins over a same-cycle timeout.
                    if (r_edge) begin
                        if (r_pcnt >= cmin) begin
                            w_stb       = 1'b1;
                            w_per_next  = r_pcnt;
                            w_pcnt_next = PCNT_W'(1);
                        end else begin
                            w_short     = 1'b1;
                            w_pcnt_next = w_pcnt_inc;
                        end
                    end else if ((cmax != '0) && (r_pcnt == cmax)) begin
                        w_to         = 1'b1;
                        w_pcnt_next  = '0;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_pcnt_next = w_pcnt_inc;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                    w_pcnt_next  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state <= ST_IDLE;
            r_pcnt  <= '0;
            r_per   <= '0;
            r_stb   <= 1'b0;
            r_first <= 1'b0;
            r_short <= 1'b0;
            r_to    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pcnt  <= w_pcnt_next;
            r_per   <= w_per_next;
            r_stb   <= w_stb;
            r_first <= w_first;
            r_short <= w_short;
            r_to    <= w_to;
        end
    end

    assign cap_lvl   = r_lvl;
    assign cap_stb   = r_stb;
    assign cap_per   = r_per;
    assign cap_first = r_first;
    assign cap_short = r_short;
    assign cap_to    = r_to;

`ifdef HWAG_CAP_STAT_EN
    logic [15:0] r_rej_cnt;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_rej_cnt <= 16'h0000;
        end else if (stat_clr) begin
            r_rej_cnt <= 16'h0000;
        end else if (w_short && (r_rej_cnt != 16'hFFFF)) begin
            r_rej_cnt <= r_rej_cnt + 16'h0001;
        end
    end

    assign cap_rej_cnt = r_rej_cnt;
`else
    logic w_unused_stat;

    assign w_unused_stat = stat_clr;
    assign cap_rej_cnt   = 16'h0000;
`endif

endmodule
